// File: rtl/npu_wb_pkg.sv
// npu_wb_pkg: shared state encoding and default widths for the NPU write-back path.
// NPU_WB_ADDR_W is also the hazard unit's address compare width.
package npu_wb_pkg;
   localparam int NPU_WB_ADDR_W = 10;
   localparam int NPU_WB_DATA_W = 32;
   localparam int NPU_WB_LEN_W  = 7;
   typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE, DONE} wb_state_e;
endpackage

// File: rtl/npu_wb_sequencer_if.sv
// npu_wb_sequencer_if: start, NPU result, memory write and status signals of the write-back sequencer.
interface npu_wb_sequencer_if
   import npu_wb_pkg::*;
#(
   parameter int ADDR_W = NPU_WB_ADDR_W,
   parameter int DATA_W = NPU_WB_DATA_W,
   parameter int LEN_W  = NPU_WB_LEN_W
);
   logic              mat_start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic              npu_valid;
   logic [DATA_W-1:0] npu_data;
   logic              npu_ready;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_is_writing;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic              EN_NPU;
   logic              done;
   logic              err;
   modport slave (
      input  mat_start, base_addr, length, npu_valid, npu_data, mem_ack,
      output npu_ready, mem_wr, mem_is_writing, mem_wdata, EN_NPU, done, err
   );
   modport master (
      output mat_start, base_addr, length, npu_valid, npu_data, mem_ack,
      input  npu_ready, mem_wr, mem_is_writing, mem_wdata, EN_NPU, done, err
   );
endinterface

// File: rtl/npu_wb_watchdog.sv
// npu_wb_watchdog: counts cycles spent waiting for a write ack; flags the last allowed cycle.
module npu_wb_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_run) r_cnt <= r_cnt + 1'b1;
   end
   // Expiring on count TIMEOUT_CYC-1 makes WRITE last exactly TIMEOUT_CYC cycles.
   assign o_expired = i_run && (r_cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/npu_wb_sequencer.sv
// npu_wb_sequencer: moves NPU result words into data memory one handshake at a time.
// Define NPU_WB_WATCHDOG_EN to abort a write whose ack never arrives and raise err.
module npu_wb_sequencer
   import npu_wb_pkg::*;
#(
   parameter int ADDR_W      = NPU_WB_ADDR_W,
   parameter int DATA_W      = NPU_WB_DATA_W,
   parameter int LEN_W       = NPU_WB_LEN_W,
   parameter int TIMEOUT_CYC = 255
) (
   input logic               clk,
   input logic               rst,
   npu_wb_sequencer_if.slave bus
);
   wb_state_e         r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_buf;
   logic              r_ready;
   logic              r_wr;
   logic              r_en;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W-1:0] w_addr;
   logic              w_expired;

   assign w_addr = r_base + ADDR_W'(r_idx);

`ifdef NPU_WB_WATCHDOG_EN
   npu_wb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == WAIT_DATA && bus.npu_valid),
      .i_run     (r_state == WRITE),
      .o_expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_buf   <= '0;
         r_ready <= 1'b0;
         r_wr    <= 1'b0;
         r_en    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.mat_start && bus.length != '0) begin
               r_base  <= bus.base_addr;
               r_len   <= bus.length;
               r_idx   <= '0;
               r_err   <= 1'b0;
               r_ready <= 1'b1;
               r_en    <= 1'b1;
               r_state <= WAIT_DATA;
            end
            WAIT_DATA: if (bus.npu_valid) begin
               r_buf   <= bus.npu_data;
               r_addr  <= w_addr;
               r_wr    <= 1'b1;
               r_ready <= 1'b0;
               r_state <= WRITE;
            end
            WRITE: if (bus.mem_ack) begin
               r_wr <= 1'b0;
               if (r_idx == r_len - 1'b1) begin
                  r_done  <= 1'b1;
                  r_en    <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_ready <= 1'b1;
                  r_state <= WAIT_DATA;
               end
            end else if (w_expired) begin
               r_wr    <= 1'b0;
               r_err   <= 1'b1;
               r_done  <= 1'b1;
               r_en    <= 1'b0;
               r_state <= DONE;
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // r_addr only updates on entry to WRITE, so the address holds between writes.
   assign bus.npu_ready      = r_ready;
   assign bus.mem_wr         = r_wr;
   assign bus.mem_is_writing = r_addr;
   assign bus.mem_wdata      = r_buf;
   assign bus.EN_NPU         = r_en;
   assign bus.done           = r_done;
   assign bus.err            = r_err;
endmodule

// File: tb/tb_npu_wb_sequencer.sv
// tb_npu_wb_sequencer: directed scenarios for the NPU write-back sequencer.
// Build with NPU_WB_WATCHDOG_EN to exercise the ack watchdog (TIMEOUT_CYC=8).
module tb_npu_wb_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   npu_wb_sequencer_if #(.ADDR_W(10), .DATA_W(32), .LEN_W(7)) bus ();
   npu_wb_sequencer #(.ADDR_W(10), .DATA_W(32), .LEN_W(7), .TIMEOUT_CYC(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      step;
      checks++;
      if ({bus.npu_ready, bus.mem_wr, bus.EN_NPU, bus.done, bus.err} !== 5'b0)
         begin failures++; $display("FAIL reset_flags got=%b want=00000", {bus.npu_ready, bus.mem_wr, bus.EN_NPU, bus.done, bus.err}); end
      checks++;
      if ({bus.mem_is_writing, bus.mem_wdata} !== 42'd0)
         begin failures++; $display("FAIL reset_bus addr=%h data=%h want 0/0", bus.mem_is_writing, bus.mem_wdata); end
      rst = 1'b0;
      step;
   endtask

   task automatic run_xfer(input logic [9:0] base, input logic [6:0] len, input int dly, input logic [31:0] d0, input bit poke);
      logic [9:0] ea;
      bus.mat_start = 1'b1;
      bus.base_addr = base;
      bus.length = len;
      step;
      bus.mat_start = 1'b0;
      checks++;
      if ({bus.npu_ready, bus.EN_NPU, bus.mem_wr, bus.done} !== 4'b1100)
         begin failures++; $display("FAIL start base=%h rdy/en/wr/done got=%b want=1100", base, {bus.npu_ready, bus.EN_NPU, bus.mem_wr, bus.done}); end
      for (int i = 0; i < int'(len); i++) begin
         bus.npu_valid = 1'b1;
         bus.npu_data = d0 + 32'(i);
         step;
         bus.npu_valid = 1'b0;
         bus.npu_data = '0;
         ea = base + 10'(i);
         if (poke && i == 0) begin
            bus.mat_start = 1'b1;
            bus.base_addr = 10'h200;
            bus.length = 7'd1;
         end
         for (int w = 0; w <= dly; w++) begin
            checks++;
            if ({bus.mem_wr, bus.npu_ready, bus.EN_NPU, bus.mem_is_writing, bus.mem_wdata} !== {3'b101, ea, d0 + 32'(i)})
               begin failures++; $display("FAIL write w%0d c%0d wr/rdy/en=%b addr=%h data=%h want 101 %h %h", i, w, {bus.mem_wr, bus.npu_ready, bus.EN_NPU}, bus.mem_is_writing, bus.mem_wdata, ea, d0 + 32'(i)); end
            if (w == dly) bus.mem_ack = 1'b1;
            step;
         end
         bus.mem_ack = 1'b0;
         bus.mat_start = 1'b0;
         checks++;
         if (i == int'(len) - 1) begin
            if ({bus.done, bus.EN_NPU, bus.mem_wr, bus.npu_ready} !== 4'b1000)
               begin failures++; $display("FAIL done base=%h done/en/wr/rdy got=%b want=1000", base, {bus.done, bus.EN_NPU, bus.mem_wr, bus.npu_ready}); end
            step;
            checks++;
            if ({bus.done, bus.EN_NPU} !== 2'b00)
               begin failures++; $display("FAIL idle_after_done done/en got=%b want=00", {bus.done, bus.EN_NPU}); end
         end else if ({bus.npu_ready, bus.mem_wr, bus.done, bus.EN_NPU} !== 4'b1001)
            begin failures++; $display("FAIL next_word w%0d rdy/wr/done/en got=%b want=1001", i, {bus.npu_ready, bus.mem_wr, bus.done, bus.EN_NPU}); end
      end
   endtask

   task automatic test_basic;
      run_xfer(10'h010, 7'd3, 0, 32'hA, 1'b0);
   endtask

   task automatic test_wrap;
      run_xfer(10'h3FE, 7'd4, 0, 32'h100, 1'b0);
   endtask

   task automatic test_backpressure;
      run_xfer(10'h020, 7'd2, 5, 32'h55, 1'b0);
   endtask

   task automatic test_ignored;
      bus.mat_start = 1'b1;
      bus.base_addr = 10'h030;
      bus.length = 7'd0;
      step;
      bus.mat_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({bus.EN_NPU, bus.npu_ready, bus.done} !== 3'b000)
            begin failures++; $display("FAIL zero_len c%0d en/rdy/done got=%b want=000", c, {bus.EN_NPU, bus.npu_ready, bus.done}); end
         step;
      end
      run_xfer(10'h040, 7'd3, 1, 32'h77, 1'b1);
   endtask

   task automatic test_back_to_back;
      run_xfer(10'h050, 7'd1, 0, 32'h1, 1'b0);
      run_xfer(10'h060, 7'd2, 0, 32'h2, 1'b0);
      bus.mat_start = 1'b1;
      bus.base_addr = 10'h070;
      bus.length = 7'd1;
      step;
      bus.mat_start = 1'b0;
      bus.npu_valid = 1'b1;
      step;
      bus.npu_valid = 1'b0;
      bus.mem_ack = 1'b1;
      step;
      bus.mem_ack = 1'b0;
      bus.mat_start = 1'b1;
      step;
      bus.mat_start = 1'b0;
      checks++;
      if ({bus.EN_NPU, bus.npu_ready, bus.done} !== 3'b000)
         begin failures++; $display("FAIL start_in_done en/rdy/done got=%b want=000", {bus.EN_NPU, bus.npu_ready, bus.done}); end
      step;
   endtask

   task automatic test_reset_mid;
      bus.mat_start = 1'b1;
      bus.base_addr = 10'h100;
      bus.length = 7'd4;
      step;
      bus.mat_start = 1'b0;
      bus.npu_valid = 1'b1;
      bus.npu_data = 32'hDEAD0001;
      step;
      bus.npu_valid = 1'b0;
      bus.mem_ack = 1'b1;
      step;
      bus.mem_ack = 1'b0;
      bus.npu_valid = 1'b1;
      bus.npu_data = 32'hDEAD0002;
      step;
      bus.npu_valid = 1'b0;
      checks++;
      if ({bus.mem_wr, bus.mem_is_writing} !== {1'b1, 10'h101})
         begin failures++; $display("FAIL mid_write wr=%b addr=%h want 1 101", bus.mem_wr, bus.mem_is_writing); end
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++;
      if ({bus.npu_ready, bus.mem_wr, bus.EN_NPU, bus.done, bus.err, bus.mem_is_writing, bus.mem_wdata} !== 47'd0)
         begin failures++; $display("FAIL mid_reset rdy/wr/en/done/err=%b addr=%h data=%h want all 0", {bus.npu_ready, bus.mem_wr, bus.EN_NPU, bus.done, bus.err}, bus.mem_is_writing, bus.mem_wdata); end
      bus.npu_valid = 1'b1;
      bus.mem_ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step;
         checks++;
         if ({bus.done, bus.mem_wr, bus.EN_NPU} !== 3'b000)
            begin failures++; $display("FAIL post_reset c%0d done/wr/en got=%b want=000", c, {bus.done, bus.mem_wr, bus.EN_NPU}); end
      end
      bus.npu_valid = 1'b0;
      bus.mem_ack = 1'b0;
      step;
   endtask

   task automatic test_watchdog;
      bus.mat_start = 1'b1;
      bus.base_addr = 10'h080;
      bus.length = 7'd2;
      step;
      bus.mat_start = 1'b0;
      bus.npu_valid = 1'b1;
      bus.npu_data = 32'hBEEF;
      step;
      bus.npu_valid = 1'b0;
`ifdef NPU_WB_WATCHDOG_EN
      for (int c = 0; c < 8; c++) begin
         checks++;
         if ({bus.mem_wr, bus.err, bus.done} !== 3'b100)
            begin failures++; $display("FAIL wdog_wait c%0d wr/err/done got=%b want=100", c, {bus.mem_wr, bus.err, bus.done}); end
         step;
      end
      checks++;
      if ({bus.mem_wr, bus.err, bus.done, bus.EN_NPU} !== 4'b0110)
         begin failures++; $display("FAIL wdog_fire wr/err/done/en got=%b want=0110", {bus.mem_wr, bus.err, bus.done, bus.EN_NPU}); end
      step;
      checks++;
      if ({bus.err, bus.done} !== 2'b10)
         begin failures++; $display("FAIL wdog_sticky err/done got=%b want=10", {bus.err, bus.done}); end
      bus.mat_start = 1'b1;
      step;
      bus.mat_start = 1'b0;
      checks++;
      if ({bus.err, bus.EN_NPU} !== 2'b01)
         begin failures++; $display("FAIL wdog_clear err/en got=%b want=01", {bus.err, bus.EN_NPU}); end
      rst = 1'b1;
      step;
      rst = 1'b0;
`else
      for (int c = 0; c < 20; c++) step;
      checks++;
      if ({bus.mem_wr, bus.err, bus.done} !== 3'b100)
         begin failures++; $display("FAIL stall_hold wr/err/done got=%b want=100", {bus.mem_wr, bus.err, bus.done}); end
      bus.mem_ack = 1'b1;
      step;
      bus.mem_ack = 1'b0;
      checks++;
      if ({bus.npu_ready, bus.mem_wr, bus.err} !== 3'b100)
         begin failures++; $display("FAIL stall_release rdy/wr/err got=%b want=100", {bus.npu_ready, bus.mem_wr, bus.err}); end
      rst = 1'b1;
      step;
      rst = 1'b0;
`endif
      step;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1);
   end

   initial begin
      bus.mat_start = 1'b0;
      bus.base_addr = '0;
      bus.length = '0;
      bus.npu_valid = 1'b0;
      bus.npu_data = '0;
      bus.mem_ack = 1'b0;
      test_reset;
      test_basic;
      test_wrap;
      test_backpressure;
      test_ignored;
      test_back_to_back;
      test_reset_mid;
      test_watchdog;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/npu_wb_sequencer.md
# npu_wb_sequencer

Write-back sequencer on the NPU side of the shared data memory. It drives the NPU busy flag, memory write strobe and current write address that the core's hazard unit compares against pending load/store addresses. After a matrix-op start, it moves NPU result words from the array output into data memory, one word per handshake. It also signals completion to the core.

## Interface
Parameters:
- ADDR_W, 10, data-memory word-address width; equals the hazard unit's address compare width
- DATA_W, 32, result word width
- LEN_W, 7, width of the transfer length field; maximum length is 2^LEN_W − 1 words
- TIMEOUT_CYC, 255, write-ack watchdog limit (used only with the watchdog macro)

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mat_start  in  1  start pulse for a matrix-op write-back
- base_addr  in  ADDR_W  first destination word address, sampled on an accepted mat_start
- length  in  LEN_W  number of words to write, sampled on an accepted mat_start
- npu_valid  in  1  NPU result word valid
- npu_data  in  DATA_W  NPU result word
- npu_ready  out  1  sequencer can accept a result word
- mem_wr  out  1  data-memory write strobe
- mem_is_writing  out  ADDR_W  address of the write in progress
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory accepted the write this cycle
- EN_NPU  out  1  NPU write-back active
- done  out  1  one-cycle completion pulse
- err  out  1  watchdog fault, sticky

## Operation
- FSM has four states: IDLE, WAIT_DATA, WRITE, DONE.
- IDLE, mat_start=1, length≠0: latch base_addr and length, clear the index, go to WAIT_DATA.
- IDLE, mat_start=1, length=0: ignored, remain in IDLE.
- mat_start outside IDLE: ignored. There is no queueing.
- WAIT_DATA:
  - npu_ready=1.
  - On npu_valid, capture npu_data into a one-word buffer and go to WRITE.
- WRITE:
  - mem_wr=1, mem_wdata=buffer, mem_is_writing=(base+idx) mod 2^ADDR_W. The address wraps silently.
  - npu_ready=0.
  - Hold until mem_ack.
  - On mem_ack, if idx=length−1 go to DONE; otherwise increment idx and go to WAIT_DATA.
- DONE: done=1 for one cycle, then go to IDLE.
- EN_NPU=1 in WAIT_DATA and WRITE only.
- mem_is_writing holds its last value outside WRITE. Consumers qualify it with mem_wr.
- mem_ack outside WRITE is ignored.
- Reset: state=IDLE; all outputs 0, including mem_is_writing=0 and err=0; buffer and index cleared.
- Reset mid-transfer aborts with no done pulse. The remaining words are not written.

## Timing
- mat_start accepted at cycle T: EN_NPU=1 and npu_ready=1 at T+1.
- npu_valid at cycle K in WAIT_DATA: mem_wr=1 at K+1.
- mem_ack at cycle J on the last word: done=1 and EN_NPU=0 at J+1; state is IDLE at J+2.
- mem_ack at cycle J on a non-last word: npu_ready=1 at J+1. Best-case throughput is one word per 2 cycles.
- A new mat_start is accepted at the earliest in the cycle after done.

## Configuration
- NPU_WB_WATCHDOG_EN defined:
  - A cycle counter runs while in WRITE and is cleared on every entry to WRITE.
  - If it reaches TIMEOUT_CYC without mem_ack: drop mem_wr, set err, go to DONE (done pulses).
  - err clears on the next accepted mat_start or on rst.
- NPU_WB_WATCHDOG_EN undefined: WRITE waits indefinitely; err is tied to 0; no counter logic.

## Structure
- Package npu_wb_pkg:
  - state enum (IDLE, WAIT_DATA, WRITE, DONE)
  - default ADDR_W, DATA_W and LEN_W constants, shared with the hazard unit's address compare width
- One natural sub-module: npu_wb_watchdog (counter and compare against TIMEOUT_CYC), instantiated only under NPU_WB_WATCHDOG_EN.

## Test plan
- Basic transfer: base=0x010, length=3, NPU data 0xA,0xB,0xC, mem_ack the same cycle as mem_wr → writes to 0x010/0x011/0x012 in order; done at ack3+1; EN_NPU high from T+1 until done.
- Wrap-around: base=0x3FE, length=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Back-pressure: mem_ack delayed 5 cycles per word → mem_wr, address and data stable throughout; npu_ready=0 during WRITE; no words lost.
- Ignored starts: length=0 → stays IDLE with no done; mat_start during a transfer → no effect on the latched base or length.
- Reset mid-transfer: rst asserted during WRITE of word 2 of 4 → next cycle all outputs 0 and IDLE; no done pulse.
- Watchdog (macro on, TIMEOUT_CYC=8): no mem_ack → after 8 WRITE cycles mem_wr=0, err=1, done pulse; the next mat_start clears err.
